// File: rtl/demux_scan_if.sv
// ============================================================================
//  Module      : demux_scan_if
//  Description : Sample stream into the demux scan sequencer. Plain
//                valid/ready handshake carrying one data bit per transfer.
//                  in_valid  producer -> sequencer   sample present
//                  in_data   producer -> sequencer   sample bit
//                  in_ready  sequencer -> producer   sample can be taken
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface demux_scan_if;
  logic in_valid;
  logic in_data;
  logic in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/demux_scan_ctrl.sv
// ============================================================================
//  Module      : demux_scan_ctrl
//  Description : Upstream sequencer for a combinational 1:4 demux. Takes one
//                sample per enabled channel over a valid/ready handshake,
//                drives it on o_a with the channel index on {o_s1,o_s0} for
//                HOLD_CYCLES cycles, then moves to the next enabled channel
//                in ascending order.
//  Ports       : clk            rising-edge clock
//                rst_n          asynchronous active-low reset
//                i_start        begin a frame (honoured in IDLE only)
//                i_stop         abort the running frame
//                i_mask[3:0]    channel enables, latched on accepted start
//                s_in           sample stream (slave side)
//                o_a            demux data input
//                o_s1, o_s0     demux select = channel index
//                o_busy         high whenever not IDLE
//                o_chan_done    one-cycle pulse on bit ch when its hold ends
//                o_frame_done   one-cycle pulse after the last channel
//  Option      : DEMUX_SCAN_LOOP_EN - wrap to the lowest enabled channel
//                instead of returning to IDLE; only stop/reset end a scan.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_scan_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              i_start,
  input  wire              i_stop,
  input  wire  [3:0]       i_mask,
  demux_scan_if.slave      s_in,
  output logic             o_a,
  output logic             o_s1,
  output logic             o_s0,
  output logic             o_busy,
  output logic [3:0]       o_chan_done,
  output logic             o_frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Counter loads HOLD_CYCLES-1 on the handshake so that o_a stays valid for
  // exactly HOLD_CYCLES cycles before the terminal (count==0) cycle ends it.
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_mask;
  logic [1:0]       r_sel;       // current channel; forced to 0 in IDLE
  logic [CNT_W-1:0] r_cnt;
  logic             r_a;
  logic             r_in_ready;
  logic             r_busy;
  logic [3:0]       r_chan_done;
  logic             r_frame_done;

  logic [1:0]       w_first_ch;  // lowest enabled channel of the live mask
  logic [1:0]       w_next_ch;   // lowest latched channel above r_sel
  logic             w_next_vld;
  logic             w_start_ok;
  logic             w_hs;
`ifdef DEMUX_SCAN_LOOP_EN
  logic [1:0]       w_wrap_ch;   // lowest latched channel, for wrap-around
`endif

  // Priority searches: iterate downwards so the last hit is the lowest index.
  always_comb begin
    w_first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_mask[i]) w_first_ch = 2'(i);
    end
    w_next_ch  = 2'd0;
    w_next_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_next_ch  = 2'(i);
        w_next_vld = 1'b1;
      end
    end
`ifdef DEMUX_SCAN_LOOP_EN
    w_wrap_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_mask[i]) w_wrap_ch = 2'(i);
    end
`endif
  end

  // Stop has priority over start when both are present in IDLE.
  assign w_start_ok = i_start & ~i_stop & (|i_mask);
  assign w_hs       = s_in.in_valid & r_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= 4'd0;
      r_sel        <= 2'd0;
      r_cnt        <= '0;
      r_a          <= 1'b0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_chan_done  <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_chan_done  <= 4'd0;
      r_frame_done <= 1'b0;
      if ((r_state != S_IDLE) && i_stop) begin
        // Abort: any sample handshaked this cycle is dropped, no pulses.
        r_state    <= S_IDLE;
        r_sel      <= 2'd0;
        r_a        <= 1'b0;
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_mask     <= i_mask;
              r_sel      <= w_first_ch;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_SEL;
            end
          end
          S_SEL: begin
            if (w_hs) begin
              r_a        <= s_in.in_data;
              r_in_ready <= 1'b0;
              r_cnt      <= c_HOLD_LAST;
              r_state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_a         <= 1'b0;
              r_chan_done <= 4'b0001 << r_sel;
              if (w_next_vld) begin
                r_sel      <= w_next_ch;
                r_in_ready <= 1'b1;
                r_state    <= S_SEL;
              end else begin
                r_frame_done <= 1'b1;
`ifdef DEMUX_SCAN_LOOP_EN
                r_sel      <= w_wrap_ch;
                r_in_ready <= 1'b1;
                r_state    <= S_SEL;
`else
                r_sel      <= 2'd0;
                r_busy     <= 1'b0;
                r_state    <= S_IDLE;
`endif
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_a        <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign o_a           = r_a;
  assign o_s1          = r_sel[1];
  assign o_s0          = r_sel[0];
  assign o_busy        = r_busy;
  assign o_chan_done   = r_chan_done;
  assign o_frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
// ============================================================================
//  Module      : tb_demux_scan_ctrl
//  Description : Self-checking bench for demux_scan_ctrl. Each frame is
//                described as an expected cycle-by-cycle timeline built from
//                the channel/hold rules, then replayed against the design.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_scan_ctrl;

  localparam int H = 4;
`ifdef DEMUX_SCAN_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] mask  = 4'd0;
  logic       a, s1, s0, busy, fd;
  logic [3:0] cd;

  int n_checks = 0;
  int n_fail   = 0;

  demux_scan_if u_if ();

  demux_scan_ctrl #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_mask       (mask),
    .s_in         (u_if.slave),
    .o_a          (a),
    .o_s1         (s1),
    .o_s0         (s0),
    .o_busy       (busy),
    .o_chan_done  (cd),
    .o_frame_done (fd)
  );

  always #5 clk = ~clk;

  // One timeline step: expected outputs for the cycle, plus inputs to drive.
  typedef struct packed {
    logic       a;
    logic [1:0] sel;
    logic       rdy;
    logic       busy;
    logic [3:0] cd;
    logic       fd;
    logic       vld;
    logic       dat;
    logic       stp;
  } step_t;

  step_t q[$];

  // Build the expected timeline for one start: every enabled channel in
  // ascending order gets (delay+1) select cycles, then H hold cycles; the
  // completion pulses land on the first cycle after the hold.
  function automatic void build(input logic [3:0] m, input int passes,
                                input bit rnd, input logic [3:0] bits,
                                input int dly0);
    step_t      e;
    logic [3:0] pcd;
    logic       pfd;
    int         first;
    q.delete();
    pcd   = 4'd0;
    pfd   = 1'b0;
    first = -1;
    for (int c = 0; c < 4; c++) if (m[c] && first < 0) first = c;
    for (int p = 0; p < passes; p++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          int   dly;
          logic b;
          dly = rnd ? int'($urandom_range(0, 3)) : ((c == first && p == 0) ? dly0 : 0);
          b   = rnd ? 1'($urandom_range(0, 1)) : bits[c];
          for (int d = 0; d <= dly; d++) begin
            e      = '0;
            e.sel  = 2'(c);
            e.rdy  = 1'b1;
            e.busy = 1'b1;
            e.cd   = pcd;
            e.fd   = pfd;
            pcd    = 4'd0;
            pfd    = 1'b0;
            e.vld  = (d == dly);
            e.dat  = (d == dly) ? b : 1'($urandom_range(0, 1));
            q.push_back(e);
          end
          for (int h = 0; h < H; h++) begin
            e      = '0;
            e.a    = b;
            e.sel  = 2'(c);
            e.busy = 1'b1;
            e.vld  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            e.dat  = 1'($urandom_range(0, 1));
            q.push_back(e);
          end
          pcd = 4'(1 << c);
        end
      end
      pfd = 1'b1;
    end
    if (LOOP) begin
      // Scan wraps; end it with a stop on the wrapped select cycle.
      e      = '0;
      e.sel  = 2'(first);
      e.rdy  = 1'b1;
      e.busy = 1'b1;
      e.cd   = pcd;
      e.fd   = pfd;
      e.stp  = 1'b1;
      q.push_back(e);
      e = '0;
      q.push_back(e);
    end else begin
      e    = '0;
      e.cd = pcd;
      e.fd = pfd;
      q.push_back(e);
    end
    e = '0;
    q.push_back(e);
  endfunction

  // Stop during step idx: the next cycle is plain IDLE with no pulses.
  function automatic void apply_stop(input int idx);
    step_t e;
    e     = q[idx];
    e.stp = 1'b1;
    q[idx] = e;
    while (q.size() > idx + 1) void'(q.pop_back());
    e = '0;
    q.push_back(e);
    q.push_back(e);
  endfunction

  // Start a frame with mask m and replay the timeline. Entered and left at
  // 1 time unit after a rising edge, with the design in IDLE.
  task automatic run(input logic [3:0] m, input string name);
    start = 1'b1;
    stop  = 1'b0;
    mask  = m;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      step_t e;
      e = q[k];
      n_checks++;
      if ({a, s1, s0, u_if.in_ready, busy, cd, fd} !==
          {e.a, e.sel, e.rdy, e.busy, e.cd, e.fd}) begin
        n_fail++;
        $display("FAIL %s step %0d: got a=%b sel=%b%b rdy=%b busy=%b cd=%b fd=%b, expected a=%b sel=%b rdy=%b busy=%b cd=%b fd=%b",
                 name, k, a, s1, s0, u_if.in_ready, busy, cd, fd,
                 e.a, e.sel, e.rdy, e.busy, e.cd, e.fd);
      end
      u_if.in_valid = e.vld;
      u_if.in_data  = e.dat;
      stop          = e.stp;
      // Start pulses and mask churn while busy must have no effect.
      start = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      mask  = 4'($urandom);
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
    stop          = 1'b0;
    start         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a, s1, s0, u_if.in_ready, busy, cd, fd} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset: got a=%b sel=%b%b rdy=%b busy=%b cd=%b fd=%b, expected all 0",
               a, s1, s0, u_if.in_ready, busy, cd, fd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    build(4'b1111, 1, 1'b0, 4'b1101, 0);
    run(4'b1111, "basic");
  endtask

  task automatic test_sparse();
    build(4'b1010, 1, 1'b0, 4'b1010, 0);
    run(4'b1010, "sparse");
  endtask

  task automatic test_sel_wait();
    build(4'b0001, 1, 1'b0, 4'b0001, 5);
    run(4'b0001, "sel_wait");
  endtask

  task automatic test_stop();
    // ch0 steps 0-4, ch1 5-9, ch2 select 10, hold 11..14: stop in step 12.
    build(4'b1111, 1, 1'b0, 4'b1101, 0);
    apply_stop(12);
    run(4'b1111, "stop");
  endtask

  task automatic test_ignore_start();
    start = 1'b1;
    mask  = 4'b0000;
    @(posedge clk); #1;
    n_checks++;
    if ({a, s1, s0, u_if.in_ready, busy, cd, fd} !== 10'd0) begin
      n_fail++;
      $display("FAIL start_mask0: got rdy=%b busy=%b sel=%b%b, expected idle zeros",
               u_if.in_ready, busy, s1, s0);
    end
    stop = 1'b1;
    mask = 4'b1111;
    @(posedge clk); #1;
    n_checks++;
    if ({a, s1, s0, u_if.in_ready, busy, cd, fd} !== 10'd0) begin
      n_fail++;
      $display("FAIL start_stop: got rdy=%b busy=%b sel=%b%b, expected idle zeros",
               u_if.in_ready, busy, s1, s0);
    end
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    mask  = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    n_checks++;
    if ({a, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL async_pre: got a=%b busy=%b, expected a=1 busy=1", a, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a, s1, s0, u_if.in_ready, busy, cd, fd} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%b sel=%b%b rdy=%b busy=%b cd=%b fd=%b, expected all 0",
               a, s1, s0, u_if.in_ready, busy, cd, fd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({a, s1, s0, u_if.in_ready, busy, cd, fd} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_after: got a=%b busy=%b cd=%b fd=%b, expected all 0",
               a, busy, cd, fd);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      build(m, 1, 1'b1, 4'd0, 0);
      if ($urandom_range(0, 2) == 0) apply_stop(int'($urandom_range(0, q.size() - 3)));
      run(m, "random");
    end
  endtask

  task automatic test_back_to_back();
    // Second frame starts in the first idle cycle after frame_done.
    build(4'b0110, 1, 1'b1, 4'd0, 0);
    void'(q.pop_back());
    run(4'b0110, "b2b_first");
    build(4'b1001, 1, 1'b1, 4'd0, 0);
    run(4'b1001, "b2b_second");
  endtask

`ifdef DEMUX_SCAN_LOOP_EN
  task automatic test_loop();
    build(4'b0001, 3, 1'b0, 4'b0001, 0);
    run(4'b0001, "loop");
  endtask
`endif

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_data  = 1'b0;
    test_reset();
    test_basic();
    test_sparse();
    test_sel_wait();
    test_stop();
    test_ignore_start();
    test_async_reset();
    test_random();
    test_back_to_back();
`ifdef DEMUX_SCAN_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
